// File: rtl/axil_xbar_pkg.sv
// Shared types and helpers for the 1-to-N AXI4-Lite crossbar.
package axil_xbar_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  // Bits needed to hold a slave index, sized as clog2(ns+1) so it is never zero-width.
  function automatic int idx_width(input int ns);
    int w;
    w = 0;
    while ((1 << w) < (ns + 1)) w++;
    return w;
  endfunction

endpackage

// File: rtl/axil_addr_decoder.sv
// Combinational address decoder: finds the lowest-index slave whose masked base matches.
module axil_addr_decoder
  import axil_xbar_pkg::*;
#(
  parameter int                      NS     = 4,
  parameter int                      ADDR_W = 32,
  parameter logic [NS*ADDR_W-1:0]    BASE   = '0,
  parameter logic [NS*ADDR_W-1:0]    MASK   = '0,
  localparam int                     SW     = idx_width(NS)
) (
  input  logic [ADDR_W-1:0] addr,
  output logic [SW-1:0]     sel,
  output logic              hit
);

  // Scan downwards so the lowest matching index is the last one written.
  always_comb begin
    hit = 1'b0;
    sel = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if ((addr & MASK[i*ADDR_W +: ADDR_W]) ==
          (BASE[i*ADDR_W +: ADDR_W] & MASK[i*ADDR_W +: ADDR_W])) begin
        hit = 1'b1;
        sel = SW'(i);
      end
    end
  end

endmodule

// File: rtl/axil_xbar_1xn.sv
// One AXI4-Lite master to NS slaves; independent read and write FSMs, unmapped
// addresses answered locally with DECERR.
module axil_xbar_1xn
  import axil_xbar_pkg::*;
#(
  parameter int                   NS     = 4,
  parameter int                   ADDR_W = 32,
  parameter int                   DATA_W = 32,
  parameter logic [NS*ADDR_W-1:0] BASE   = {32'h1000_2000, 32'h0200_0000, 32'h1000_0000, 32'h8000_0000},
  parameter logic [NS*ADDR_W-1:0] MASK   = {32'hFFFF_F000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFF00_0000}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_arvalid,
  output logic                       in_arready,
  input  logic [ADDR_W-1:0]          in_araddr,
  output logic                       in_rvalid,
  input  logic                       in_rready,
  output logic [DATA_W-1:0]          in_rdata,
  output logic [1:0]                 in_rresp,
  input  logic                       in_awvalid,
  output logic                       in_awready,
  input  logic [ADDR_W-1:0]          in_awaddr,
  input  logic                       in_wvalid,
  output logic                       in_wready,
  input  logic [DATA_W-1:0]          in_wdata,
  input  logic [DATA_W/8-1:0]        in_wstrb,
  output logic                       in_bvalid,
  input  logic                       in_bready,
  output logic [1:0]                 in_bresp,
  output logic [NS-1:0]              out_arvalid,
  input  logic [NS-1:0]              out_arready,
  output logic [NS*ADDR_W-1:0]       out_araddr,
  input  logic [NS-1:0]              out_rvalid,
  output logic [NS-1:0]              out_rready,
  input  logic [NS*DATA_W-1:0]       out_rdata,
  input  logic [NS*2-1:0]            out_rresp,
  output logic [NS-1:0]              out_awvalid,
  input  logic [NS-1:0]              out_awready,
  output logic [NS*ADDR_W-1:0]       out_awaddr,
  output logic [NS-1:0]              out_wvalid,
  input  logic [NS-1:0]              out_wready,
  output logic [NS*DATA_W-1:0]       out_wdata,
  output logic [NS*(DATA_W/8)-1:0]   out_wstrb,
  input  logic [NS-1:0]              out_bvalid,
  output logic [NS-1:0]              out_bready,
  input  logic [NS*2-1:0]            out_bresp
);

  localparam int SW = idx_width(NS);

  logic [SW-1:0] ar_sel, aw_sel;
  logic          ar_hit, aw_hit;

  r_state_e      r_state_q, r_state_d;
  logic [SW-1:0] r_sel_q, r_sel_d;
  logic          r_err_q, r_err_d;

  w_state_e      w_state_q, w_state_d;
  logic [SW-1:0] w_sel_q, w_sel_d;
  logic          w_err_q, w_err_d;

  axil_addr_decoder #(
    .NS(NS), .ADDR_W(ADDR_W), .BASE(BASE), .MASK(MASK)
  ) u_ar_dec (
    .addr(in_araddr),
    .sel (ar_sel),
    .hit (ar_hit)
  );

  axil_addr_decoder #(
    .NS(NS), .ADDR_W(ADDR_W), .BASE(BASE), .MASK(MASK)
  ) u_aw_dec (
    .addr(in_awaddr),
    .sel (aw_sel),
    .hit (aw_hit)
  );

  // Address and write payload go to every slave; only the valids select one.
  assign out_araddr = {NS{in_araddr}};
  assign out_awaddr = {NS{in_awaddr}};
  assign out_wdata  = {NS{in_wdata}};
  assign out_wstrb  = {NS{in_wstrb}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state_q <= R_IDLE;
      r_sel_q   <= '0;
      r_err_q   <= 1'b0;
      w_state_q <= W_IDLE;
      w_sel_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_sel_q   <= r_sel_d;
      r_err_q   <= r_err_d;
      w_state_q <= w_state_d;
      w_sel_q   <= w_sel_d;
      w_err_q   <= w_err_d;
    end
  end

  // Read path. All handshakes are gated by rst so outputs fall the moment reset rises.
  always_comb begin
    r_state_d   = r_state_q;
    r_sel_d     = r_sel_q;
    r_err_d     = r_err_q;
    in_arready  = 1'b0;
    in_rvalid   = 1'b0;
    in_rdata    = '0;
    in_rresp    = RESP_OKAY;
    out_arvalid = '0;
    out_rready  = '0;
    if (!rst) begin
      unique case (r_state_q)
        R_IDLE: begin
          if (ar_hit) begin
            for (int i = 0; i < NS; i++) begin
              if (ar_sel == SW'(i)) begin
                out_arvalid[i] = in_arvalid;
                in_arready     = out_arready[i];
              end
            end
          end else begin
            in_arready = 1'b1;
          end
          if (in_arvalid && in_arready) begin
            r_sel_d   = ar_sel;
            r_err_d   = !ar_hit;
            r_state_d = R_DATA;
          end
        end
        R_DATA: begin
          if (r_err_q) begin
            in_rvalid = 1'b1;
            in_rresp  = RESP_DECERR;
          end else begin
            for (int i = 0; i < NS; i++) begin
              if (r_sel_q == SW'(i)) begin
                in_rvalid     = out_rvalid[i];
                in_rdata      = out_rdata[i*DATA_W +: DATA_W];
                in_rresp      = out_rresp[i*2 +: 2];
                out_rready[i] = in_rready;
              end
            end
          end
          if (in_rvalid && in_rready) r_state_d = R_IDLE;
        end
        default: r_state_d = R_IDLE;
      endcase
    end
  end

  // Write path: AW first, then W, then B; W is never taken before AW.
  always_comb begin
    w_state_d   = w_state_q;
    w_sel_d     = w_sel_q;
    w_err_d     = w_err_q;
    in_awready  = 1'b0;
    in_wready   = 1'b0;
    in_bvalid   = 1'b0;
    in_bresp    = RESP_OKAY;
    out_awvalid = '0;
    out_wvalid  = '0;
    out_bready  = '0;
    if (!rst) begin
      unique case (w_state_q)
        W_IDLE: begin
          if (aw_hit) begin
            for (int i = 0; i < NS; i++) begin
              if (aw_sel == SW'(i)) begin
                out_awvalid[i] = in_awvalid;
                in_awready     = out_awready[i];
              end
            end
          end else begin
            in_awready = 1'b1;
          end
          if (in_awvalid && in_awready) begin
            w_sel_d   = aw_sel;
            w_err_d   = !aw_hit;
            w_state_d = W_DATA;
          end
        end
        W_DATA: begin
          if (w_err_q) begin
            in_wready = 1'b1;
          end else begin
            for (int i = 0; i < NS; i++) begin
              if (w_sel_q == SW'(i)) begin
                out_wvalid[i] = in_wvalid;
                in_wready     = out_wready[i];
              end
            end
          end
          if (in_wvalid && in_wready) w_state_d = W_RESP;
        end
        W_RESP: begin
          if (w_err_q) begin
            in_bvalid = 1'b1;
            in_bresp  = RESP_DECERR;
          end else begin
            for (int i = 0; i < NS; i++) begin
              if (w_sel_q == SW'(i)) begin
                in_bvalid     = out_bvalid[i];
                in_bresp      = out_bresp[i*2 +: 2];
                out_bready[i] = in_bready;
              end
            end
          end
          if (in_bvalid && in_bready) w_state_d = W_IDLE;
        end
        default: w_state_d = W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_xbar_1xn.sv
// Directed bench for axil_xbar_1xn with simple always-ready slave models.
module tb_axil_xbar_1xn;

  localparam int NS    = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 50;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_arvalid = 1'b0, in_arready;
  logic [AW-1:0]        in_araddr = '0;
  logic                 in_rvalid, in_rready = 1'b0;
  logic [DW-1:0]        in_rdata;
  logic [1:0]           in_rresp;
  logic                 in_awvalid = 1'b0, in_awready;
  logic [AW-1:0]        in_awaddr = '0;
  logic                 in_wvalid = 1'b0, in_wready;
  logic [DW-1:0]        in_wdata = '0;
  logic [DW/8-1:0]      in_wstrb = '0;
  logic                 in_bvalid, in_bready = 1'b0;
  logic [1:0]           in_bresp;
  logic [NS-1:0]        out_arvalid, out_arready, out_rvalid, out_rready;
  logic [NS*AW-1:0]     out_araddr, out_awaddr;
  logic [NS*DW-1:0]     out_rdata, out_wdata;
  logic [NS*2-1:0]      out_rresp, out_bresp;
  logic [NS-1:0]        out_awvalid, out_awready, out_wvalid, out_wready, out_bvalid, out_bready;
  logic [NS*DW/8-1:0]   out_wstrb;

  int check_count = 0;
  int error_count = 0;

  // Slave model state
  logic [DW-1:0]   rd_data [NS];
  int              rd_lat [NS];
  int              rcnt [NS];
  logic [NS-1:0]   s_rvalid, s_bvalid;
  int              arv_cnt [NS], awv_cnt [NS], wv_cnt [NS];
  int              ar_fire_cnt [NS], aw_fire_cnt [NS], w_fire_cnt [NS];
  logic [AW-1:0]   awaddr_cap [NS];
  logic [DW-1:0]   wdata_cap [NS];
  logic [DW/8-1:0] wstrb_cap [NS];
  int              aw_time [NS], w_time [NS];
  int              cycle, rfire_cnt;

  always #5 clk = ~clk;

  axil_xbar_1xn dut (
    .clk(clk), .rst(rst),
    .in_arvalid(in_arvalid), .in_arready(in_arready), .in_araddr(in_araddr),
    .in_rvalid(in_rvalid), .in_rready(in_rready), .in_rdata(in_rdata), .in_rresp(in_rresp),
    .in_awvalid(in_awvalid), .in_awready(in_awready), .in_awaddr(in_awaddr),
    .in_wvalid(in_wvalid), .in_wready(in_wready), .in_wdata(in_wdata), .in_wstrb(in_wstrb),
    .in_bvalid(in_bvalid), .in_bready(in_bready), .in_bresp(in_bresp),
    .out_arvalid(out_arvalid), .out_arready(out_arready), .out_araddr(out_araddr),
    .out_rvalid(out_rvalid), .out_rready(out_rready), .out_rdata(out_rdata), .out_rresp(out_rresp),
    .out_awvalid(out_awvalid), .out_awready(out_awready), .out_awaddr(out_awaddr),
    .out_wvalid(out_wvalid), .out_wready(out_wready), .out_wdata(out_wdata), .out_wstrb(out_wstrb),
    .out_bvalid(out_bvalid), .out_bready(out_bready), .out_bresp(out_bresp)
  );

  assign out_arready = '1;
  assign out_awready = '1;
  assign out_wready  = '1;
  assign out_rvalid  = s_rvalid;
  assign out_bvalid  = s_bvalid;
  assign out_rresp   = '0;
  assign out_bresp   = '0;

  always_comb begin
    out_rdata = '0;
    for (int i = 0; i < NS; i++) out_rdata[i*DW +: DW] = rd_data[i];
  end

  // Slaves accept addresses at once, answer reads after rd_lat cycles and writes one cycle after W.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_rvalid  <= '0;
      s_bvalid  <= '0;
      cycle     <= 0;
      rfire_cnt <= 0;
      for (int i = 0; i < NS; i++) begin
        rcnt[i] <= 0; arv_cnt[i] <= 0; awv_cnt[i] <= 0; wv_cnt[i] <= 0;
        ar_fire_cnt[i] <= 0; aw_fire_cnt[i] <= 0; w_fire_cnt[i] <= 0;
        awaddr_cap[i] <= '0; wdata_cap[i] <= '0; wstrb_cap[i] <= '0;
        aw_time[i] <= 0; w_time[i] <= 0;
      end
    end else begin
      cycle <= cycle + 1;
      if (in_rvalid && in_rready) rfire_cnt <= rfire_cnt + 1;
      for (int i = 0; i < NS; i++) begin
        if (out_arvalid[i]) arv_cnt[i] <= arv_cnt[i] + 1;
        if (out_awvalid[i]) awv_cnt[i] <= awv_cnt[i] + 1;
        if (out_wvalid[i])  wv_cnt[i]  <= wv_cnt[i] + 1;
        if (out_arvalid[i] && out_arready[i]) begin
          ar_fire_cnt[i] <= ar_fire_cnt[i] + 1;
          rcnt[i]        <= rd_lat[i];
        end else if (rcnt[i] != 0) begin
          if (rcnt[i] == 1) s_rvalid[i] <= 1'b1;
          rcnt[i] <= rcnt[i] - 1;
        end
        if (s_rvalid[i] && out_rready[i]) s_rvalid[i] <= 1'b0;
        if (out_awvalid[i] && out_awready[i]) begin
          aw_fire_cnt[i] <= aw_fire_cnt[i] + 1;
          awaddr_cap[i]  <= out_awaddr[i*AW +: AW];
          aw_time[i]     <= cycle;
        end
        if (out_wvalid[i] && out_wready[i]) begin
          w_fire_cnt[i] <= w_fire_cnt[i] + 1;
          wdata_cap[i]  <= out_wdata[i*DW +: DW];
          wstrb_cap[i]  <= out_wstrb[i*(DW/8) +: DW/8];
          w_time[i]     <= cycle;
          s_bvalid[i]   <= 1'b1;
        end else if (s_bvalid[i] && out_bready[i]) begin
          s_bvalid[i] <= 1'b0;
        end
      end
    end
  end

  function automatic int activity();
    int s;
    s = 0;
    for (int i = 0; i < NS; i++) s += arv_cnt[i] + awv_cnt[i] + wv_cnt[i];
    return s;
  endfunction

  function automatic int others_arv(input int k);
    int s;
    s = 0;
    for (int i = 0; i < NS; i++) if (i != k) s += arv_cnt[i];
    return s;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic ar_handshake(input logic [AW-1:0] addr, output int waited);
    @(negedge clk);
    in_arvalid = 1'b1;
    in_araddr  = addr;
    #1;
    waited = 0;
    while (!in_arready && waited < LIMIT) begin @(negedge clk); #1; waited++; end
    checkOutput("ar_timeout", 64'(waited >= LIMIT), 64'd0);
    @(negedge clk);
    in_arvalid = 1'b0;
  endtask

  task automatic aw_handshake(input logic [AW-1:0] addr, output int waited);
    @(negedge clk);
    in_awvalid = 1'b1;
    in_awaddr  = addr;
    #1;
    waited = 0;
    while (!in_awready && waited < LIMIT) begin @(negedge clk); #1; waited++; end
    checkOutput("aw_timeout", 64'(waited >= LIMIT), 64'd0);
    @(negedge clk);
    in_awvalid = 1'b0;
  endtask

  task automatic w_handshake(input logic [DW-1:0] data, input logic [DW/8-1:0] strb);
    int waited;
    @(negedge clk);
    in_wvalid = 1'b1;
    in_wdata  = data;
    in_wstrb  = strb;
    #1;
    waited = 0;
    while (!in_wready && waited < LIMIT) begin @(negedge clk); #1; waited++; end
    checkOutput("w_timeout", 64'(waited >= LIMIT), 64'd0);
    @(negedge clk);
    in_wvalid = 1'b0;
  endtask

  task automatic r_collect(output logic [DW-1:0] data, output logic [1:0] resp, output int waited);
    in_rready = 1'b1;
    #1;
    waited = 0;
    while (!in_rvalid && waited < LIMIT) begin @(negedge clk); #1; waited++; end
    checkOutput("r_timeout", 64'(waited >= LIMIT), 64'd0);
    data = in_rdata;
    resp = in_rresp;
    @(negedge clk);
    in_rready = 1'b0;
  endtask

  task automatic b_collect(output logic [1:0] resp);
    int waited;
    in_bready = 1'b1;
    #1;
    waited = 0;
    while (!in_bvalid && waited < LIMIT) begin @(negedge clk); #1; waited++; end
    checkOutput("b_timeout", 64'(waited >= LIMIT), 64'd0);
    resp = in_bresp;
    @(negedge clk);
    in_bready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rdata;
    logic [1:0]    rresp, bresp;
    int            arw, rw, aww, act0, arf0, awf0, rf0;

    for (int i = 0; i < NS; i++) begin rd_data[i] = '0; rd_lat[i] = 1; end

    // Reset: drive requests that would otherwise route, everything must stay quiet.
    in_arvalid = 1'b1; in_araddr = 32'h3000_0000;
    in_awvalid = 1'b1; in_awaddr = 32'h8000_0000;
    in_rready  = 1'b1; in_bready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_arready",   64'(in_arready),  64'd0);
    checkOutput("rst_awready",   64'(in_awready),  64'd0);
    checkOutput("rst_out_arv",   64'(out_arvalid), 64'd0);
    checkOutput("rst_out_awv",   64'(out_awvalid), 64'd0);
    checkOutput("rst_rvalid",    64'(in_rvalid),   64'd0);
    checkOutput("rst_bvalid",    64'(in_bvalid),   64'd0);
    checkOutput("rst_wready",    64'(in_wready),   64'd0);
    checkOutput("rst_resp_data", {in_rdata, in_rresp, in_bresp}, 64'd0);
    in_arvalid = 1'b0; in_awvalid = 1'b0; in_rready = 1'b0; in_bready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Test 1: hit read on slave0 with 3-cycle latency
    rd_data[0] = 32'hDEAD_BEEF; rd_lat[0] = 3;
    arf0 = ar_fire_cnt[0]; act0 = others_arv(0); rf0 = rfire_cnt;
    ar_handshake(32'h8000_0010, arw);
    checkOutput("t1_ar_wait", 64'(arw), 64'd0);
    r_collect(rdata, rresp, rw);
    checkOutput("t1_rdata",  64'(rdata), 64'hDEAD_BEEF);
    checkOutput("t1_rresp",  64'(rresp), 64'd0);
    checkOutput("t1_r_lat",  64'(rw),    64'd3);
    checkOutput("t1_s0_ar",  64'(ar_fire_cnt[0] - arf0), 64'd1);
    checkOutput("t1_oth_ar", 64'(others_arv(0) - act0),  64'd0);
    checkOutput("t1_rpulse", 64'(rfire_cnt - rf0),       64'd1);

    // Test 2: hit write to slave1, W two cycles after AW
    aw_handshake(32'h1000_03F8, aww);
    w_handshake(32'h0000_0041, 4'b0001);
    b_collect(bresp);
    checkOutput("t2_awaddr", 64'(awaddr_cap[1]), 64'h1000_03F8);
    checkOutput("t2_wdata",  64'(wdata_cap[1]),  64'h41);
    checkOutput("t2_wstrb",  64'(wstrb_cap[1]),  64'b0001);
    checkOutput("t2_w_gap",  64'(w_time[1] - aw_time[1]), 64'd2);
    checkOutput("t2_bresp",  64'(bresp), 64'd0);

    // Test 3: read miss answered locally with DECERR
    act0 = activity();
    ar_handshake(32'h3000_0000, arw);
    checkOutput("t3_ar_same", 64'(arw), 64'd0);
    r_collect(rdata, rresp, rw);
    checkOutput("t3_r_next",  64'(rw),    64'd0);
    checkOutput("t3_rdata",   64'(rdata), 64'd0);
    checkOutput("t3_rresp",   64'(rresp), 64'b11);
    #1;
    checkOutput("t3_r_done",  64'(in_rvalid), 64'd0);
    checkOutput("t3_no_out",  64'(activity() - act0), 64'd0);

    // Test 4: write miss, W offered with AW, B back-pressured for 5 cycles
    act0 = activity();
    @(negedge clk);
    in_awvalid = 1'b1; in_awaddr = 32'h0000_0000;
    in_wvalid  = 1'b1; in_wdata  = 32'h1234_5678; in_wstrb = 4'hF;
    #1;
    checkOutput("t4_awready", 64'(in_awready), 64'd1);
    checkOutput("t4_w_early", 64'(in_wready),  64'd0);
    @(negedge clk);
    in_awvalid = 1'b0;
    #1;
    checkOutput("t4_wready",  64'(in_wready),  64'd1);
    @(negedge clk);
    in_wvalid = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      checkOutput("t4_b_hold", {in_bvalid, in_bresp}, 64'b111);
      @(negedge clk);
      #1;
    end
    in_bready = 1'b1;
    @(negedge clk);
    in_bready = 1'b0;
    in_wvalid = 1'b1;
    #1;
    checkOutput("t4_b_done",  64'(in_bvalid), 64'd0);
    checkOutput("t4_idle",    64'(in_wready), 64'd0);
    in_wvalid = 1'b0;
    checkOutput("t4_no_out",  64'(activity() - act0), 64'd0);

    // Test 5: concurrent read of slave2 and write to slave3
    rd_data[2] = 32'hCAFE_F00D; rd_lat[2] = 2;
    arf0 = ar_fire_cnt[2]; awf0 = aw_fire_cnt[3];
    @(negedge clk);
    in_arvalid = 1'b1; in_araddr = 32'h0200_BFF8;
    in_awvalid = 1'b1; in_awaddr = 32'h1000_2004;
    #1;
    checkOutput("t5_both_rdy", {in_arready, in_awready}, 64'b11);
    @(negedge clk);
    in_arvalid = 1'b0; in_awvalid = 1'b0;
    checkOutput("t5_s2_ar", 64'(ar_fire_cnt[2] - arf0), 64'd1);
    checkOutput("t5_s3_aw", 64'(aw_fire_cnt[3] - awf0), 64'd1);
    fork
      begin
        r_collect(rdata, rresp, rw);
      end
      begin
        w_handshake(32'hA5A5_0003, 4'b1100);
        b_collect(bresp);
      end
    join
    checkOutput("t5_rdata",  64'(rdata), 64'hCAFE_F00D);
    checkOutput("t5_rresp",  64'(rresp), 64'd0);
    checkOutput("t5_wdata",  64'(wdata_cap[3]), 64'hA5A5_0003);
    checkOutput("t5_wstrb",  64'(wstrb_cap[3]), 64'b1100);
    checkOutput("t5_bresp",  64'(bresp), 64'd0);

    // Test 6: reset while waiting for slave0 read data
    rd_lat[0] = 10;
    ar_handshake(32'h8000_0000, arw);
    in_rready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("t6_rready_pre", 64'(out_rready), 64'b0001);
    rst = 1'b1;
    #1;
    checkOutput("t6_rready_rst", 64'(out_rready), 64'd0);
    checkOutput("t6_rvalid_rst", 64'(in_rvalid),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    in_rready = 1'b0;
    rd_data[0] = 32'h0BAD_F00D; rd_lat[0] = 1;
    ar_handshake(32'h8000_0000, arw);
    r_collect(rdata, rresp, rw);
    checkOutput("t6_rdata", 64'(rdata), 64'h0BAD_F00D);
    checkOutput("t6_rresp", 64'(rresp), 64'd0);
    checkOutput("t6_r_lat", 64'(rw),    64'd1);

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/axil_xbar_1xn.md
Name: axil_xbar_1xn

Overview:
Parametrised 1-master to NS-slave AXI4-Lite crossbar; next generation of the 2-target (SRAM/UART) xbar that sits between the NPC LSU/IFU arbiter and the peripherals.
- Address map comes from parameters instead of hard-coded compares.
- Read and write paths are independent FSMs, so one read and one write can be in flight at the same time.
- Unmapped addresses complete locally with DECERR.

Parameters:
NS, 4, number of downstream slaves (1..8)
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8
BASE, {32'h1000_2000,32'h0200_0000,32'h1000_0000,32'h8000_0000}, packed NS*ADDR_W slave base addresses; slave i is at [i*ADDR_W +: ADDR_W]
MASK, {32'hFFFF_F000,32'hFFFF_0000,32'hFFFF_F000,32'hFF00_0000}, packed NS*ADDR_W compare masks

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
in_arvalid/in_arready  in/out  1  upstream AR handshake
in_araddr  in  ADDR_W  read address
in_rvalid/in_rready  out/in  1  upstream R handshake
in_rdata  out  DATA_W  read data
in_rresp  out  2  read response
in_awvalid/in_awready  in/out  1  upstream AW handshake
in_awaddr  in  ADDR_W  write address
in_wvalid/in_wready  in/out  1  upstream W handshake
in_wdata  in  DATA_W  write data
in_wstrb  in  DATA_W/8  write strobe
in_bvalid/in_bready  out/in  1  upstream B handshake
in_bresp  out  2  write response
out_arvalid/out_arready  out/in  NS  per-slave AR handshake
out_araddr  out  NS*ADDR_W  per-slave read address (broadcast)
out_rvalid/out_rready  in/out  NS  per-slave R handshake
out_rdata  in  NS*DATA_W  per-slave read data
out_rresp  in  NS*2  per-slave read response
out_awvalid/out_awready  out/in  NS  per-slave AW handshake
out_awaddr  out  NS*ADDR_W  per-slave write address (broadcast)
out_wvalid/out_wready  out/in  NS  per-slave W handshake
out_wdata  out  NS*DATA_W  per-slave write data (broadcast)
out_wstrb  out  NS*DATA_W/8  per-slave strobe (broadcast)
out_bvalid/out_bready  in/out  NS  per-slave B handshake
out_bresp  in  NS*2  per-slave write response

Behaviour:
- Decode: slave i hits when (addr & MASK_i) == (BASE_i & MASK_i). If several hit, the lowest index wins. No hit means a miss.
- Reset: clk and rst only; rst is asynchronous and active-high.
  - While rst is high: both FSMs are IDLE, and every upstream ready/valid and every out_*valid/out_*ready is 0.
  - in_rdata, in_rresp and in_bresp are 0.
- Read FSM, state R_IDLE:
  - out_arvalid[sel] = in_arvalid; in_arready = out_arready[sel].
  - On a miss, in_arready = 1.
  - On AR fire: latch sel and err; go to R_DATA.
  - No extra latency on a hit.
- Read FSM, state R_DATA:
  - Hit: in_rvalid/rdata/rresp are muxed from slave sel; out_rready[sel] = in_rready.
  - Miss: in_rvalid = 1 (registered, first cycle after AR fire), in_rdata = 0, in_rresp = 2'b11.
  - On R fire: return to R_IDLE. A new AR is accepted no earlier than the next cycle.
- Write FSM, state W_IDLE:
  - AW is routed like AR.
  - On AW fire: latch sel and err; go to W_DATA.
  - in_wready = 0 in W_IDLE. W is never accepted before AW.
- Write FSM, state W_DATA:
  - Hit: out_wvalid[sel] = in_wvalid; in_wready = out_wready[sel].
  - Miss: in_wready = 1 and data is dropped.
  - On W fire: go to W_RESP.
- Write FSM, state W_RESP:
  - Hit: B is routed from sel.
  - Miss: registered bvalid with bresp = 2'b11.
  - On B fire: return to W_IDLE.
- Concurrency:
  - Read and write FSMs never block each other. The old "AW has priority over AR" gating is removed.
  - A read and a write may target the same slave at once; the slave must tolerate this, as the AXI-Lite spec allows.
- Unselected slaves see valid = 0 and ready = 0 at all times.
- Upstream rule: once valid is asserted, the address must be held until ready. The xbar re-decodes each cycle and relies on this stability.
- Asynchronous reset mid-transaction: both FSMs return to IDLE and all outputs drop immediately. Pending slave transactions are abandoned, and the system resets slaves together with the xbar.

Decomposition:
- Package axil_xbar_pkg:
  - RESP_OKAY = 2'b00, RESP_DECERR = 2'b11.
  - Read FSM enum: R_IDLE, R_DATA.
  - Write FSM enum: W_IDLE, W_DATA, W_RESP.
  - Index width function clog2(NS+1).
- Sub-module axil_addr_decoder (combinational; parameters NS/ADDR_W/BASE/MASK):
  - Output sel index and hit.
  - Instantiated twice, once for AR and once for AW.

Test Plan:
1. Read 0x8000_0010, slave0 responds rdata = 0xDEADBEEF after 3 cycles -> one in_rvalid pulse with rdata 0xDEADBEEF, rresp 00; out_arvalid[1..3] never asserted.
2. Write 0x1000_03F8, wdata 0x41, wstrb 4'b0001, with W presented 2 cycles after AW -> slave1 sees AW, then W with 0x41 and strobe 0001; in_bresp 00.
3. Read 0x3000_0000 (miss) -> in_arready = 1 in the same cycle, in_rvalid the next cycle, rdata 0, rresp 11; no out_* activity.
4. Write to miss 0x0000_0000 with in_bready held low for 5 cycles -> in_bvalid stays 1 with bresp 11 until bready, then W_IDLE.
5. Simultaneous read of 0x0200_BFF8 (slave2) and write to 0x1000_2004 (slave3) in the same cycle -> both ARs/AWs fire that cycle; R and B complete independently with correct data.
6. Assert rst for 1 cycle while R_DATA waits on slave0 -> in_rvalid and out_rready drop at once, and a fresh read to 0x8000_0000 after reset completes normally.
